// File: rtl/rvx_bus_arbiter_if.sv
// Request/response signal bundle shared by the arbiter's upstream manager
// ports and its downstream bus port.
//   master modport: drives address, write data/strobe and the two requests;
//                   receives read data and the two completion responses.
//   slave  modport: the mirror image, for the side that serves the requests.
interface rvx_bus_arbiter_if;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;

    modport master (
        output rw_address, read_request, write_data, write_strobe, write_request,
        input  read_data, read_response, write_response
    );

    modport slave (
        input  rw_address, read_request, write_data, write_strobe, write_request,
        output read_data, read_response, write_response
    );
endinterface

// File: rtl/rvx_bus_arbiter.sv
// Two-manager round-robin arbiter in front of the single system-bus manager
// port. Manager 0 is the core, manager 1 the debug/DMA engine. One transaction
// is outstanding at a time; a transaction that sees no matching response
// within TIMEOUT_CYCLES wait cycles is force-completed.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   m0, m1         upstream manager bundles (slave side of rvx_bus_arbiter_if)
//   bus            downstream bundle towards the interconnect (master side)
//   bus_owner      manager owning the current or last transaction
//   timeout_error  1-cycle pulse when a transaction is force-completed
module rvx_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES    = 256,
    parameter logic [31:0] TIMEOUT_READ_DATA = 32'h00000000
) (
    input  logic                     clock,
    input  logic                     reset,
    rvx_bus_arbiter_if.slave         m0,
    rvx_bus_arbiter_if.slave         m1,
    rvx_bus_arbiter_if.master        bus,
    output logic                     bus_owner,
    output logic                     timeout_error
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_next;
    logic          owner, owner_next;
    logic          kind_write, kind_write_next;
    logic          last_grant, last_grant_next;
    logic [TW-1:0] timer, timer_next;

    logic        m0_req, m1_req;
    logic        winner, sel;
    logic        sel_write;
    logic        bus_rd_req, bus_wr_req;
    logic        done, expired, respond;
    logic        rsp_read, rsp_write;
    logic [31:0] rsp_data;

    assign m0_req = m0.read_request | m0.write_request;
    assign m1_req = m1.read_request | m1.write_request;

    // Tie goes to the manager not granted last; otherwise the lone requester.
    assign winner = m0_req ? (m1_req ? ~last_grant : 1'b0) : 1'b1;
    assign sel    = (state == IDLE) ? winner : owner;

    // A manager raising both requests is treated as a write.
    assign sel_write = sel ? m1.write_request : m0.write_request;

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        kind_write_next = kind_write;
        last_grant_next = last_grant;
        timer_next      = timer;
        bus_rd_req      = 1'b0;
        bus_wr_req      = 1'b0;
        done            = 1'b0;
        expired         = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    bus_wr_req      = sel_write;
                    bus_rd_req      = ~sel_write;
                    owner_next      = winner;
                    kind_write_next = sel_write;
                    last_grant_next = winner;
                    timer_next      = '0;
                    state_next      = WAIT;
                end
            end
            WAIT: begin
                done    = kind_write ? bus.write_response : bus.read_response;
                expired = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST) && !done;
                if (timer != '1)
                    timer_next = timer + TW'(1);
                if (done || expired)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            kind_write <= 1'b0;
            last_grant <= 1'b1;
            timer      <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            kind_write <= kind_write_next;
            last_grant <= last_grant_next;
            timer      <= timer_next;
        end
    end

    // All pulses are forced low while reset is held, even mid-transaction.
    assign respond   = (done | expired) & ~reset;
    assign rsp_read  = respond & ~kind_write;
    assign rsp_write = respond & kind_write;
    assign rsp_data  = done ? bus.read_data : TIMEOUT_READ_DATA;

    assign m0.read_response  = rsp_read  & ~owner;
    assign m0.write_response = rsp_write & ~owner;
    assign m1.read_response  = rsp_read  & owner;
    assign m1.write_response = rsp_write & owner;
    assign m0.read_data      = (rsp_read & ~owner) ? rsp_data : '0;
    assign m1.read_data      = (rsp_read & owner)  ? rsp_data : '0;

    assign bus.rw_address    = sel ? m1.rw_address   : m0.rw_address;
    assign bus.write_data    = sel ? m1.write_data   : m0.write_data;
    assign bus.write_strobe  = sel ? m1.write_strobe : m0.write_strobe;
    assign bus.read_request  = bus_rd_req & ~reset;
    assign bus.write_request = bus_wr_req & ~reset;

    assign bus_owner     = owner;
    assign timeout_error = expired & ~reset;
endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Scoreboard bench for rvx_bus_arbiter (TIMEOUT_CYCLES = 4). Stimulus pushes
// expected bus requests and upstream completions, each tagged with the cycle
// it must appear in; a negedge monitor pops and compares whenever the DUT
// presents a request or a response.
module tb_rvx_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bus_owner;
    logic        timeout_error;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    rvx_bus_arbiter_if m0_if ();
    rvx_bus_arbiter_if m1_if ();
    rvx_bus_arbiter_if bus_if ();

    rvx_bus_arbiter #(
        .TIMEOUT_CYCLES    (4),
        .TIMEOUT_READ_DATA (32'h00000000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .m0            (m0_if),
        .m1            (m1_if),
        .bus           (bus_if),
        .bus_owner     (bus_owner),
        .timeout_error (timeout_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          owner;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        int unsigned when;
    } bus_exp_t;

    // rsp bits: {m1 write, m1 read, m0 write, m0 read}
    typedef struct {
        logic [3:0]  rsp;
        logic [31:0] rdata;
        bit          tmo;
        bit          owner;
        int unsigned when;
    } up_exp_t;

    bus_exp_t bq[$];
    up_exp_t  uq[$];

    task automatic push_bus(bit owner, bit is_write, logic [31:0] addr,
                            logic [31:0] wdata, logic [3:0] strobe, int unsigned when);
        bus_exp_t e;
        e.owner = owner; e.is_write = is_write; e.addr = addr;
        e.wdata = wdata; e.strobe = strobe; e.when = when;
        bq.push_back(e);
    endtask

    task automatic push_up(logic [3:0] rsp, logic [31:0] rdata, bit tmo,
                           bit owner, int unsigned when);
        up_exp_t e;
        e.rsp = rsp; e.rdata = rdata; e.tmo = tmo; e.owner = owner; e.when = when;
        uq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_quiet(string name);
        logic [6:0] act;
        @(negedge clock);
        act = {bus_if.read_request, bus_if.write_request, timeout_error,
               m1_if.write_response, m1_if.read_response,
               m0_if.write_response, m0_if.read_response};
        checks++;
        if (act != '0) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b expected=0000000", name, cyc, act);
        end
    endtask

    // Monitor
    bus_exp_t    be;
    up_exp_t     ue;
    logic [3:0]  rsp_v;
    logic [31:0] exp_m0_rd, exp_m1_rd;

    always @(negedge clock) begin
        rsp_v = {m1_if.write_response, m1_if.read_response,
                 m0_if.write_response, m0_if.read_response};
        if (bus_if.read_request || bus_if.write_request) begin
            checks++;
            if (bq.size() == 0) begin
                failures++;
                $display("FAIL bus_unexpected cyc=%0d got rd=%b wr=%b addr=%h expected no request",
                         cyc, bus_if.read_request, bus_if.write_request, bus_if.rw_address);
            end else begin
                be = bq.pop_front();
                if (bus_if.write_request !== be.is_write || bus_if.read_request !== !be.is_write ||
                    bus_if.rw_address !== be.addr || cyc != be.when ||
                    (be.is_write && (bus_if.write_data !== be.wdata ||
                                     bus_if.write_strobe !== be.strobe))) begin
                    failures++;
                    $display("FAIL bus_request cyc=%0d got wr=%b rd=%b addr=%h data=%h strb=%b expected cyc=%0d wr=%b addr=%h data=%h strb=%b",
                             cyc, bus_if.write_request, bus_if.read_request, bus_if.rw_address,
                             bus_if.write_data, bus_if.write_strobe, be.when, be.is_write,
                             be.addr, be.wdata, be.strobe);
                end
            end
        end
        if (rsp_v != '0 || timeout_error) begin
            checks++;
            if (uq.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected cyc=%0d got rsp=%b tmo=%b expected none",
                         cyc, rsp_v, timeout_error);
            end else begin
                ue = uq.pop_front();
                exp_m0_rd = ue.rsp[0] ? ue.rdata : 32'h0;
                exp_m1_rd = ue.rsp[2] ? ue.rdata : 32'h0;
                if (rsp_v !== ue.rsp || timeout_error !== ue.tmo || bus_owner !== ue.owner ||
                    cyc != ue.when || m0_if.read_data !== exp_m0_rd ||
                    m1_if.read_data !== exp_m1_rd) begin
                    failures++;
                    $display("FAIL response cyc=%0d got rsp=%b tmo=%b owner=%b rd0=%h rd1=%h expected cyc=%0d rsp=%b tmo=%b owner=%b rd0=%h rd1=%h",
                             cyc, rsp_v, timeout_error, bus_owner, m0_if.read_data,
                             m1_if.read_data, ue.when, ue.rsp, ue.tmo, ue.owner,
                             exp_m0_rd, exp_m1_rd);
                end
            end
        end else begin
            checks++;
            if (m0_if.read_data !== 32'h0 || m1_if.read_data !== 32'h0) begin
                failures++;
                $display("FAIL idle_read_data cyc=%0d got rd0=%h rd1=%h expected 0",
                         cyc, m0_if.read_data, m1_if.read_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
        $fatal(1);
    end

    initial begin
        m0_if.rw_address = '0; m0_if.read_request = 0; m0_if.write_request = 0;
        m0_if.write_data = '0; m0_if.write_strobe = '0;
        m1_if.rw_address = '0; m1_if.read_request = 0; m1_if.write_request = 0;
        m1_if.write_data = '0; m1_if.write_strobe = '0;
        bus_if.read_data = '0; bus_if.read_response = 0; bus_if.write_response = 0;

        tick(); tick();
        @(negedge clock);
        checks++;
        if (bus_owner !== 1'b0) begin
            failures++;
            $display("FAIL reset_owner got=%b expected=0", bus_owner);
        end

        // Alternating writes from both managers, 1-wait-state bus.
        m0_if.rw_address = 32'h00000100; m0_if.write_data = 32'hA5A5A5A5; m0_if.write_strobe = 4'b1111;
        m1_if.rw_address = 32'h00000200; m1_if.write_data = 32'h12345678; m1_if.write_strobe = 4'b0011;
        m0_if.write_request = 1; m1_if.write_request = 1;
        bus_if.write_response = 1;
        expect_quiet("reset_gated");
        tick();
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                push_bus(0, 1, 32'h00000100, 32'hA5A5A5A5, 4'b1111, cyc + 2 * k);
                push_up(4'b0010, 32'h0, 0, 0, cyc + 2 * k + 1);
            end else begin
                push_bus(1, 1, 32'h00000200, 32'h12345678, 4'b0011, cyc + 2 * k);
                push_up(4'b1000, 32'h0, 0, 1, cyc + 2 * k + 1);
            end
        end
        repeat (8) tick();
        m0_if.write_request = 0; m1_if.write_request = 0;
        bus_if.write_response = 0;

        // m0 read, response one cycle later.
        m0_if.rw_address = 32'h00000010; m0_if.read_request = 1;
        push_bus(0, 0, 32'h00000010, 32'h0, 4'h0, cyc);
        tick();
        bus_if.read_response = 1; bus_if.read_data = 32'hCAFEF00D;
        push_up(4'b0001, 32'hCAFEF00D, 0, 0, cyc);
        tick();
        m0_if.read_request = 0; bus_if.read_response = 0;

        // m1 read times out in the 4th wait cycle; late response ignored.
        m1_if.rw_address = 32'h00000300; m1_if.read_request = 1;
        bus_if.read_data = 32'h55AA55AA;
        push_bus(1, 0, 32'h00000300, 32'h0, 4'h0, cyc);
        push_up(4'b0100, 32'h0, 1, 1, cyc + 4);
        repeat (5) tick();
        m1_if.read_request = 0;
        bus_if.read_response = 1;
        expect_quiet("late_response_ignored");
        tick();
        expect_quiet("late_response_ignored2");
        bus_if.read_response = 0;
        tick();

        // m0 read+write together: write wins.
        m0_if.rw_address = 32'h80000000; m0_if.write_data = 32'h0BADC0DE; m0_if.write_strobe = 4'b1111;
        m0_if.read_request = 1; m0_if.write_request = 1;
        push_bus(0, 1, 32'h80000000, 32'h0BADC0DE, 4'b1111, cyc);
        tick();
        bus_if.write_response = 1; bus_if.read_response = 1;
        push_up(4'b0010, 32'h0, 0, 0, cyc);
        tick();
        m0_if.read_request = 0; m0_if.write_request = 0;
        bus_if.write_response = 0; bus_if.read_response = 0;

        // Reset during m1 read WAIT; first post-reset tie goes to m0.
        m1_if.rw_address = 32'h00000400; m1_if.read_request = 1;
        push_bus(1, 0, 32'h00000400, 32'h0, 4'h0, cyc);
        tick();
        reset = 1;
        m0_if.rw_address = 32'h00000500; m0_if.read_request = 1;
        bus_if.read_response = 1; bus_if.read_data = 32'h99999999;
        expect_quiet("reset_mid_wait");
        tick();
        reset = 0; bus_if.read_response = 0;
        push_bus(0, 0, 32'h00000500, 32'h0, 4'h0, cyc);
        tick();
        bus_if.read_response = 1; bus_if.read_data = 32'h0000BEEF;
        push_up(4'b0001, 32'h0000BEEF, 0, 0, cyc);
        tick();
        m0_if.read_request = 0; bus_if.read_response = 0;
        push_bus(1, 0, 32'h00000400, 32'h0, 4'h0, cyc);

        // Wrong-kind response ignored while waiting on a read.
        tick();
        bus_if.write_response = 1;
        tick();
        tick();
        tick();
        bus_if.write_response = 0;
        bus_if.read_response = 1; bus_if.read_data = 32'h13572468;
        push_up(4'b0100, 32'h13572468, 0, 1, cyc);
        tick();
        m1_if.read_request = 0; bus_if.read_response = 0;
        tick(); tick();

        checks++;
        if (bq.size() != 0) begin
            failures++;
            $display("FAIL bus_queue_drained got=%0d expected=0", bq.size());
        end
        checks++;
        if (uq.size() != 0) begin
            failures++;
            $display("FAIL rsp_queue_drained got=%0d expected=0", uq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
